mtm_row_feeder: RTL and testbench

- Upstream stage of the matrix-transpose unit (mtm_unit).
- Accepts a word-serial coefficient stream through a valid/ready handshake and packs it into NUM_PE-word rows.
- Buffers complete NUM_PE x NUM_PE tiles in a ping-pong pair.
- Emits each tile as exactly NUM_PE back-to-back row_val cycles, because the transpose controller requires contiguous row bursts and cannot stall.

---
 rtl/mtm_pkg.sv | 15 +
 rtl/mtm_tile_buffer.sv | 74 +++++++
 rtl/mtm_row_feeder.sv | 153 +++++++++++++++
 tb/tb_mtm_row_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_pkg.sv
// Shared types and default sizes for the matrix-transpose front end.
package mtm_pkg;

    localparam int unsigned MTM_DATA_WIDTH = 64;
    localparam int unsigned MTM_NUM_PE     = 8;
    localparam int unsigned TILE_IDX_W     = $clog2(MTM_NUM_PE);

    typedef logic [MTM_DATA_WIDTH-1:0] row_t [0:MTM_NUM_PE-1];

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } feed_state_e;

endpackage

// File: rtl/mtm_tile_buffer.sv
// Ping-pong tile storage: lane-wide write port, registered full-row read port.
// Reads past a tile's fill count return zero so partially filled tiles drain cleanly.
module mtm_tile_buffer
    import mtm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int unsigned NUM_PE     = MTM_NUM_PE,
    parameter int unsigned IN_WORDS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           wr_tile,
    input  logic [$clog2(NUM_PE)-1:0]      wr_row,
    input  logic [$clog2(NUM_PE)-1:0]      wr_col,
    input  logic [DATA_WIDTH*IN_WORDS-1:0] wr_data,
    input  logic                           rd_en,
    input  logic                           rd_tile,
    input  logic [$clog2(NUM_PE)-1:0]      rd_row,
    output logic [DATA_WIDTH-1:0]          rd_data [0:NUM_PE-1]
);

    localparam int unsigned IDX_W = $clog2(NUM_PE);
    localparam int unsigned CNT_W = $clog2(NUM_PE * NUM_PE + 1);

    logic [DATA_WIDTH-1:0] mem       [0:1][0:NUM_PE-1][0:NUM_PE-1];
    logic [CNT_W-1:0]      cnt_q     [0:1];
    logic [CNT_W-1:0]      cnt_d     [0:1];
    logic [DATA_WIDTH-1:0] rd_data_q [0:NUM_PE-1];
    logic [DATA_WIDTH-1:0] rd_data_d [0:NUM_PE-1];

    // Word storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int w = 0; w < IN_WORDS; w++) begin
                mem[wr_tile][wr_row][wr_col + IDX_W'(w)] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Fill count restarts naturally when a tile is refilled from position 0.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_tile] = CNT_W'(wr_row) * CNT_W'(NUM_PE) + CNT_W'(wr_col) + CNT_W'(IN_WORDS);
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            for (int j = 0; j < NUM_PE; j++) begin
                if (CNT_W'(rd_row) * CNT_W'(NUM_PE) + CNT_W'(j) < cnt_q[rd_tile]) begin
                    rd_data_d[j] = mem[rd_tile][rd_row][j];
                end else begin
                    rd_data_d[j] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            rd_data_q <= '{default: '0};
        end else begin
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mtm_row_feeder.sv
// Packs a word-serial stream into NUM_PE x NUM_PE tiles and emits each as a contiguous row burst.
// Optional MTM_FEED_FLUSH_EN adds a flush input that closes a partially filled tile.
module mtm_row_feeder
    import mtm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int unsigned NUM_PE     = MTM_NUM_PE,
    parameter int unsigned IN_WORDS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*IN_WORDS-1:0] in_data,
`ifdef MTM_FEED_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           out_hold,
    output logic                           row_val,
    output logic [DATA_WIDTH-1:0]          row_data [0:NUM_PE-1],
    output logic                           busy
);

    localparam int unsigned IDX_W = (NUM_PE == MTM_NUM_PE) ? TILE_IDX_W : $clog2(NUM_PE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_PE - IN_WORDS);

    feed_state_e      state_q, state_d;
    logic [IDX_W-1:0] col_q, col_d, row_q, row_d, rd_row_q, rd_row_d;
    logic             wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic             row_val_q, row_val_d, busy_q, busy_d;
    logic             accept, tile_done, rd_en;
    logic [IDX_W-1:0] rd_addr;

    assign in_ready = !full_q[wr_sel_q] && !rst;
    assign accept   = in_valid && in_ready;

    // Fill-side pointers; tile_done marks the edge where the fill tile becomes full.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        wr_sel_d  = wr_sel_q;
        tile_done = 1'b0;
        if (accept) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_IDX) begin
                    tile_done = 1'b1;
                end else begin
                    row_d = row_q + IDX_W'(1);
                end
            end else begin
                col_d = col_q + IDX_W'(IN_WORDS);
            end
        end
`ifdef MTM_FEED_FLUSH_EN
        if (flush && in_ready && (accept || row_q != '0 || col_q != '0)) begin
            tile_done = 1'b1;
        end
`endif
        if (tile_done) begin
            wr_sel_d = !wr_sel_q;
            row_d    = '0;
            col_d    = '0;
        end
    end

    // Drain FSM; out_hold only matters when a new tile burst would start.
    always_comb begin
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_sel_d  = rd_sel_q;
        row_val_d = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_row_q;
        full_d    = full_q;
        if (tile_done) begin
            full_d[wr_sel_q] = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (full_q[rd_sel_q] && !out_hold) begin
                    rd_en     = 1'b1;
                    rd_addr   = '0;
                    row_val_d = 1'b1;
                    rd_row_d  = IDX_W'(1);
                    state_d   = BURST;
                end
            end
            BURST: begin
                rd_en     = 1'b1;
                row_val_d = 1'b1;
                rd_row_d  = rd_row_q + IDX_W'(1);
                if (rd_row_q == LAST_IDX) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = !rd_sel_q;
                    if (!(full_q[!rd_sel_q] && !out_hold)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = full_d[0] | full_d[1] | (state_d == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_row_q  <= '0;
            full_q    <= '0;
            row_val_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            rd_row_q  <= rd_row_d;
            full_q    <= full_d;
            row_val_q <= row_val_d;
            busy_q    <= busy_d;
        end
    end

    assign row_val = row_val_q;
    assign busy    = busy_q;

    mtm_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PE     (NUM_PE),
        .IN_WORDS   (IN_WORDS)
    ) u_tile_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_tile (wr_sel_q),
        .wr_row  (row_q),
        .wr_col  (col_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_tile (rd_sel_q),
        .rd_row  (rd_addr),
        .rd_data (row_data)
    );

endmodule

// File: tb/tb_mtm_row_feeder.sv
// Directed bench for mtm_row_feeder (NUM_PE=8, IN_WORDS=1); flush scenario built when MTM_FEED_FLUSH_EN is defined.
module tb_mtm_row_feeder;
    import mtm_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned NP = 8;
    localparam int unsigned IW = 1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_hold = 1'b0;
    logic [DW*IW-1:0] in_data = '0;
    logic          in_ready, row_val, busy;
    logic [DW-1:0] row_data [0:NP-1];
`ifdef MTM_FEED_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_hs = 0;
    int   stalls = 0;
    int   mon_cyc [$];
    row_t mon_rows [$];

    mtm_row_feeder #(.DATA_WIDTH(DW), .NUM_PE(NP), .IN_WORDS(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef MTM_FEED_FLUSH_EN
        .flush    (flush),
`endif
        .out_hold (out_hold),
        .row_val  (row_val),
        .row_data (row_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records every registered row together with the edge that produced it.
    always begin
        @(posedge clk);
        #1;
        if (row_val === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_rows.push_back(row_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (in_ready !== 1'b1 && n < 300) begin
            stalls++;
            step(1);
            n++;
        end
        if (n >= 300) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        step(1);
        last_hs  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        #1 rst = 1'b1;
        #2;
        bad = 0;
        for (int j = 0; j < NP; j++) if (row_data[j] !== '0) bad++;
        checks += 4;
        if (row_val !== 1'b0) begin errors++; $display("FAIL rst_row_val: got %b required 0", row_val); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (bad != 0) begin errors++; $display("FAIL rst_row_data: nonzero words=%0d required 0", bad); end
        step(2);
        rst = 1'b0;
        step(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_tile();
        int e;
        mon_cyc.delete(); mon_rows.delete();
        for (int i = 0; i < 64; i++) push(DW'(i));
        e = last_hs;
        step(12);
        for (int r = 0; r < 8; r++) begin
            int bj;
            bj = -1;
            if (r < mon_rows.size())
                for (int j = 0; j < 8; j++) if (bj < 0 && mon_rows[r][j] !== DW'(r*8+j)) bj = j;
            checks++;
            if (r >= mon_rows.size() || mon_cyc[r] != e + 1 + r || bj >= 0) begin
                errors++;
                $display("FAIL single_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", r, mon_rows.size(), (r < mon_cyc.size()) ? mon_cyc[r] : -1, e + 1 + r, bj);
            end
        end
        checks += 2;
        if (mon_rows.size() != 8) begin errors++; $display("FAIL single_count: got %0d rows required 8", mon_rows.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int e [3];
        mon_cyc.delete(); mon_rows.delete();
        stalls = 0;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++) push(DW'(t*64 + i));
            e[t] = last_hs;
        end
        step(12);
        checks += 3;
        if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d required 0", stalls); end
        if (mon_rows.size() != 24) begin errors++; $display("FAIL b2b_count: got %0d rows required 24", mon_rows.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", busy); end
        for (int k = 0; k < 24; k++) begin
            int bj, t, r;
            t = k / 8; r = k % 8; bj = -1;
            if (k < mon_rows.size())
                for (int j = 0; j < 8; j++) if (bj < 0 && mon_rows[k][j] !== DW'(t*64 + r*8 + j)) bj = j;
            checks++;
            if (k >= mon_rows.size() || mon_cyc[k] != e[t] + 1 + r || bj >= 0) begin
                errors++;
                $display("FAIL b2b_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", k, mon_rows.size(), (k < mon_cyc.size()) ? mon_cyc[k] : -1, e[t] + 1 + r, bj);
            end
        end
    endtask

    task automatic test_backpressure();
        int e0;
        mon_cyc.delete(); mon_rows.delete();
        out_hold = 1'b1;
        for (int i = 0; i < 128; i++) push(DW'(i));
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b required 0", in_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b required 1", busy); end
        step(3);
        checks++;
        if (mon_rows.size() != 0) begin errors++; $display("FAIL bp_held: got %0d rows required 0", mon_rows.size()); end
        e0 = cyc;
        out_hold = 1'b0;
        step(7);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_early: got %b required 0", in_ready); end
        step(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b required 1", in_ready); end
        step(12);
        for (int k = 0; k < 16; k++) begin
            int bj;
            bj = -1;
            if (k < mon_rows.size())
                for (int j = 0; j < 8; j++) if (bj < 0 && mon_rows[k][j] !== DW'(k*8 + j)) bj = j;
            checks++;
            if (k >= mon_rows.size() || mon_cyc[k] != e0 + 1 + k || bj >= 0) begin
                errors++;
                $display("FAIL bp_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", k, mon_rows.size(), (k < mon_cyc.size()) ? mon_cyc[k] : -1, e0 + 1 + k, bj);
            end
        end
    endtask

    task automatic test_hold_boundary();
        int e0, e1;
        mon_cyc.delete(); mon_rows.delete();
        out_hold = 1'b1;
        for (int i = 0; i < 128; i++) push(DW'(1000 + i));
        e0 = cyc;
        out_hold = 1'b0;
        step(4);
        checks++;
        if (row_val !== 1'b1) begin errors++; $display("FAIL hold_row3_val: got %b required 1", row_val); end
        out_hold = 1'b1;
        step(14);
        checks += 2;
        if (mon_rows.size() != 8) begin errors++; $display("FAIL hold_first_count: got %0d rows required 8", mon_rows.size()); end
        if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b required 1", busy); end
        e1 = cyc;
        out_hold = 1'b0;
        step(12);
        checks += 2;
        if (mon_rows.size() != 16) begin errors++; $display("FAIL hold_total_count: got %0d rows required 16", mon_rows.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end: got %b required 0", busy); end
        for (int k = 0; k < 16; k++) begin
            int bj, c;
            bj = -1;
            c  = (k < 8) ? e0 + 1 + k : e1 + 1 + (k - 8);
            if (k < mon_rows.size())
                for (int j = 0; j < 8; j++) if (bj < 0 && mon_rows[k][j] !== DW'(1000 + k*8 + j)) bj = j;
            checks++;
            if (k >= mon_rows.size() || mon_cyc[k] != c || bj >= 0) begin
                errors++;
                $display("FAIL hold_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", k, mon_rows.size(), (k < mon_cyc.size()) ? mon_cyc[k] : -1, c, bj);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int e;
        mon_cyc.delete(); mon_rows.delete();
        for (int i = 0; i < 64; i++) push(DW'(2000 + i));
        for (int i = 0; i < 3; i++) push(DW'(64'hdead));
        step(1);
        checks += 2;
        if (row_val !== 1'b1) begin errors++; $display("FAIL rmb_pre_val: got %b required 1", row_val); end
        if (mon_rows.size() != 4) begin errors++; $display("FAIL rmb_pre_rows: got %0d required 4", mon_rows.size()); end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (row_val !== 1'b0) begin errors++; $display("FAIL rmb_async_val: got %b required 0", row_val); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmb_async_busy: got %b required 0", busy); end
        #2 rst = 1'b0;
        step(1);
        mon_cyc.delete(); mon_rows.delete();
        step(12);
        checks++;
        if (mon_rows.size() != 0) begin errors++; $display("FAIL rmb_no_rows: got %0d rows required 0", mon_rows.size()); end
        for (int i = 0; i < 64; i++) push(DW'(3000 + i));
        e = last_hs;
        step(12);
        checks++;
        if (mon_rows.size() != 8) begin errors++; $display("FAIL rmb_new_count: got %0d rows required 8", mon_rows.size()); end
        for (int r = 0; r < 8; r++) begin
            int bj;
            bj = -1;
            if (r < mon_rows.size())
                for (int j = 0; j < 8; j++) if (bj < 0 && mon_rows[r][j] !== DW'(3000 + r*8 + j)) bj = j;
            checks++;
            if (r >= mon_rows.size() || mon_cyc[r] != e + 1 + r || bj >= 0) begin
                errors++;
                $display("FAIL rmb_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", r, mon_rows.size(), (r < mon_cyc.size()) ? mon_cyc[r] : -1, e + 1 + r, bj);
            end
        end
    endtask

`ifdef MTM_FEED_FLUSH_EN
    task automatic test_flush();
        int f;
        mon_cyc.delete(); mon_rows.delete();
        for (int i = 0; i < 19; i++) push(DW'(4000 + i));
        flush = 1'b1;
        step(1);
        f = cyc;
        flush = 1'b0;
        step(12);
        checks++;
        if (mon_rows.size() != 8) begin errors++; $display("FAIL flush_count: got %0d rows required 8", mon_rows.size()); end
        for (int r = 0; r < 8; r++) begin
            int bj;
            logic [DW-1:0] exp_w;
            bj = -1;
            if (r < mon_rows.size())
                for (int j = 0; j < 8; j++) begin
                    exp_w = (r*8 + j < 19) ? DW'(4000 + r*8 + j) : '0;
                    if (bj < 0 && mon_rows[r][j] !== exp_w) bj = j;
                end
            checks++;
            if (r >= mon_rows.size() || mon_cyc[r] != f + 1 + r || bj >= 0) begin
                errors++;
                $display("FAIL flush_row%0d: rows=%0d cyc=%0d req_cyc=%0d bad_col=%0d", r, mon_rows.size(), (r < mon_cyc.size()) ? mon_cyc[r] : -1, f + 1 + r, bj);
            end
        end
        mon_cyc.delete(); mon_rows.delete();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(12);
        checks += 2;
        if (mon_rows.size() != 0) begin errors++; $display("FAIL flush_empty_rows: got %0d required 0", mon_rows.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty_busy: got %b required 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_backpressure();
        test_hold_boundary();
        test_reset_mid_burst();
`ifdef MTM_FEED_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
